imem_loader: RTL

- Writer-side counterpart to instruction fetch.
- Receives a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction memory at the byte address the fetch path later reads (BASE_ADDR + 4*index).
- Holds the core (cpu_hold) until a load completes with a correct checksum.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_word_assembler.sv | 51 +++++
 rtl/imem_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Types and defaults shared by the instruction-memory loader and the fetch path.
// The load stream is: length (16-bit, big-endian), 4*length payload bytes, XOR checksum byte.
package imem_loader_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0004_0000;
   localparam int          DEFAULT_DEPTH     = 101;
   localparam int          IMEM_WORD_W       = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_WRITE,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } loader_state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs payload bytes MSB-first into 32-bit words and keeps a running XOR checksum.
module imem_word_assembler
   import imem_loader_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_i,
   input  logic                   byte_en_i,
   input  logic [7:0]             byte_i,
   output logic [IMEM_WORD_W-1:0] word_o,
   output logic                   word_full_o,
   output logic [7:0]             csum_o
);

   logic [IMEM_WORD_W-1:0] word_q, word_d;
   logic [1:0]             cnt_q, cnt_d;
   logic [7:0]             csum_q, csum_d;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      csum_d = csum_q;
      if (clear_i) begin
         word_d = '0;
         cnt_d  = '0;
         csum_d = '0;
      end else if (byte_en_i) begin
         word_d = {word_q[IMEM_WORD_W-9:0], byte_i};
         cnt_d  = cnt_q + 2'd1;
         csum_d = csum_q ^ byte_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
         csum_q <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
         csum_q <= csum_d;
      end
   end

   // High while the byte that completes the current word is being accepted.
   assign word_full_o = byte_en_i && (cnt_q == 2'd3);
   assign word_o      = word_q;
   assign csum_o      = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory and
// holds the core until a load completes cleanly.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int          DEPTH     = DEFAULT_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   byte_valid,
   input  logic [7:0]             byte_data,
   output logic                   byte_ready,
   output logic                   mem_we,
   output logic [31:0]            mem_addr,
   output logic [IMEM_WORD_W-1:0] mem_wdata,
   output logic [15:0]            word_count,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic                   cpu_hold,
   output loader_state_e          state_o
);

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   loader_state_e          state_q, state_d;
   logic [15:0]            len_q, len_d;
   logic [15:0]            wc_q, wc_d;
   logic [31:0]            addr_q, addr_d;
   logic [IMEM_WORD_W-1:0] wdata_q, wdata_d;

   logic                   launch;
   logic                   asm_en;
   logic                   word_full;
   logic [IMEM_WORD_W-1:0] asm_word;
   logic [7:0]             asm_csum;
   logic [15:0]            len_full;
   logic [31:0]            wr_addr;

   // Handshake: a byte transfers on a rising edge only when byte_valid && byte_ready;
   // byte_ready depends on state alone, so it never waits on byte_valid.
   assign launch   = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
   assign len_full = {len_q[15:8], byte_data};
   assign wr_addr  = BASE_ADDR + {14'b0, wc_q, 2'b00};

   imem_word_assembler u_asm (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (launch),
      .byte_en_i   (asm_en),
      .byte_i      (byte_data),
      .word_o      (asm_word),
      .word_full_o (word_full),
      .csum_o      (asm_csum)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      wc_d       = wc_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      asm_en     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d = ST_LEN_HI;
               wc_d    = '0;
            end
         end
         ST_LEN_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               len_d[15:8] = byte_data;
               state_d     = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               len_d = len_full;
               if (len_full > DEPTH_W)      state_d = ST_ERROR;
               else if (len_full == 16'd0)  state_d = ST_CHECK;
               else                         state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            byte_ready = 1'b1;
            asm_en     = byte_valid;
            if (byte_valid && word_full) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            mem_we  = 1'b1;
            addr_d  = wr_addr;
            wdata_d = asm_word;
            wc_d    = wc_q + 16'd1;
            state_d = ((wc_q + 16'd1) == len_q) ? ST_CHECK : ST_DATA;
         end
         ST_CHECK: begin
            byte_ready = 1'b1;
            if (byte_valid) state_d = (byte_data == asm_csum) ? ST_DONE : ST_ERROR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         wc_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wc_q    <= wc_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Write address/data are live during WRITE and held afterwards.
   assign mem_addr   = mem_we ? wr_addr  : addr_q;
   assign mem_wdata  = mem_we ? asm_word : wdata_q;
   assign word_count = wc_q;
   assign busy       = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_WRITE, ST_CHECK};
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERROR);
   assign cpu_hold   = (state_q != ST_DONE);
   assign state_o    = state_q;

endmodule
